// File: rtl/conv1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv1_pkg
//  Description : Shared conv1 types, default widths and the output
//                shift / ReLU / saturate helper used by the MAC accumulator
//                and the pooling stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package conv1_pkg;

  // Window sequencing states.
  typedef enum logic [1:0] {
    ST_ACC = 2'd0,
    ST_FIN = 2'd1,
    ST_OUT = 2'd2
  } state_t;

  localparam int DEF_PROD_W = 25;
  localparam int DEF_OUT_W  = 16;

  // Arithmetic right shift (floor), optional clamp of negatives to zero,
  // then saturation into a signed out_w-bit range. The result is returned
  // at 64 bits; callers narrow it to their output width.
  function automatic logic signed [63:0] sat_relu(
    input logic signed [63:0] acc,
    input int                 shift,
    input int                 out_w,
    input logic               relu_en
  );
    logic signed [63:0] r;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    r     = acc >>> shift;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_w - 1));
    if (relu_en && (r < 64'sd0)) begin
      r = 64'sd0;
    end
    if (r > max_v) begin
      r = max_v;
    end else if (r < min_v) begin
      r = min_v;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv1_mac_accum_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv1_mac_accum_if
//  Description : Product input stream (with per-window bias) and result
//                pixel output stream of the conv1 MAC accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface conv1_mac_accum_if
  import conv1_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int OUT_W  = DEF_OUT_W
);

  logic signed [PROD_W-1:0] prod_dout;
  logic                     prod_vld;
  logic                     prod_rdy;
  logic signed [PROD_W-1:0] bias;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_vld;
  logic                     out_rdy;

  // Producer of products and consumer of result pixels.
  modport master (
    output prod_dout, prod_vld, bias, out_rdy,
    input  prod_rdy, out_data, out_vld
  );

  // The accumulator itself.
  modport slave (
    input  prod_dout, prod_vld, bias, out_rdy,
    output prod_rdy, out_data, out_vld
  );

endinterface
`default_nettype wire

// File: rtl/conv1_tap_counter.sv
`default_nettype none
// ============================================================================
//  Module      : conv1_tap_counter
//  Description : Modulo-N_TAPS tap counter with increment, synchronous clear
//                (priority) and a last-tap decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv1_tap_counter #(
  parameter int N_TAPS = 25,
  parameter int CNT_W  = 5
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_inc,
  input  wire logic             i_clr,
  output logic      [CNT_W-1:0] o_cnt,
  output logic                  o_last
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(N_TAPS - 1));

  // Count accepted taps, wrapping after the last tap of a window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = w_last;

endmodule
`default_nettype wire

// File: rtl/conv1_mac_accum.sv
`default_nettype none
// ============================================================================
//  Module      : conv1_mac_accum
//  Description : Accumulates N_TAPS signed products plus a per-window bias,
//                rescales, optionally applies ReLU, saturates and presents
//                one pixel per window on a valid/ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv1_mac_accum
  import conv1_pkg::*;
#(
  parameter int PROD_W     = DEF_PROD_W,
  parameter int N_TAPS     = 25,
  parameter int ACC_W      = 30,
  parameter int FRAC_SHIFT = 8,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int RELU_EN    = 1
) (
  input  wire logic       ap_clk,
  input  wire logic       ap_rst_n,
  input  wire logic       sync_clr,
  conv1_mac_accum_if.slave strm,
  output logic            busy
);

  localparam int CNT_W = $clog2(N_TAPS);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [OUT_W-1:0]   r_out_data;
  logic                      r_out_vld;
  logic                      w_prod_rdy;
  logic                      w_tap;
  logic                      w_last;
  logic        [CNT_W-1:0]   w_tap_cnt;
  logic                      w_first;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_bias_ext;

  // Ready is a pure decode of the registered state; a tap coinciding with
  // sync_clr is consumed upstream but never counted or accumulated.
  assign w_prod_rdy = (r_state == ST_ACC);
  assign w_tap      = strm.prod_vld && w_prod_rdy && !sync_clr;
  assign w_first    = (w_tap_cnt == '0);
  assign w_prod_ext = ACC_W'(strm.prod_dout);
  assign w_bias_ext = ACC_W'(strm.bias);

  conv1_tap_counter #(
    .N_TAPS (N_TAPS),
    .CNT_W  (CNT_W)
  ) u_tap_counter (
    .clk    (ap_clk),
    .rst_n  (ap_rst_n),
    .i_inc  (w_tap),
    .i_clr  (sync_clr),
    .o_cnt  (w_tap_cnt),
    .o_last (w_last)
  );

  // State register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= ST_ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; sync_clr returns to accumulation from any state.
  always_comb begin
    w_state_nxt = r_state;
    if (sync_clr) begin
      w_state_nxt = ST_ACC;
    end else begin
      case (r_state)
        ST_ACC:  if (w_tap && w_last) w_state_nxt = ST_FIN;
        ST_FIN:  w_state_nxt = ST_OUT;
        ST_OUT:  if (strm.out_rdy) w_state_nxt = ST_ACC;
        default: w_state_nxt = ST_ACC;
      endcase
    end
  end

  // Window accumulator: the first tap seeds it with the bias.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_acc <= '0;
    end else if (w_tap) begin
      r_acc <= (w_first ? w_bias_ext : r_acc) + w_prod_ext;
    end
  end

  // Output registers: result captured in FIN, valid tracks the OUT state.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
    end else begin
      r_out_vld <= (w_state_nxt == ST_OUT);
      if ((r_state == ST_FIN) && !sync_clr) begin
        r_out_data <= OUT_W'(sat_relu(64'(r_acc), FRAC_SHIFT, OUT_W, RELU_EN != 0));
      end
    end
  end

  assign strm.prod_rdy = w_prod_rdy;
  assign strm.out_vld  = r_out_vld;
  assign strm.out_data = r_out_data;
  assign busy          = (w_tap_cnt != '0) || (r_state != ST_ACC);

endmodule
`default_nettype wire

// File: tb/tb_conv1_mac_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv1_mac_accum
//  Description : Directed and randomized bench for conv1_mac_accum. Two
//                instances (ReLU off / on) receive identical stimulus and are
//                compared against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv1_mac_accum;

  localparam int C_PROD_W = 25;
  localparam int C_OUT_W  = 16;
  localparam int C_N      = 25;
  localparam int C_FRAC   = 8;

  logic                       ap_clk = 1'b0;
  logic                       ap_rst_n = 1'b0;
  logic                       sync_clr = 1'b0;
  logic signed [C_PROD_W-1:0] prod_dout = '0;
  logic signed [C_PROD_W-1:0] bias = '0;
  logic                       prod_vld = 1'b0;
  logic                       out_rdy = 1'b0;
  logic                       busy_lin;
  logic                       busy_relu;

  int n_chk = 0;
  int n_err = 0;

  longint win[C_N];
  longint win_bias;

  conv1_mac_accum_if #(.PROD_W(C_PROD_W), .OUT_W(C_OUT_W)) if_lin ();
  conv1_mac_accum_if #(.PROD_W(C_PROD_W), .OUT_W(C_OUT_W)) if_relu ();

  assign if_lin.prod_dout  = prod_dout;
  assign if_lin.prod_vld   = prod_vld;
  assign if_lin.bias       = bias;
  assign if_lin.out_rdy    = out_rdy;
  assign if_relu.prod_dout = prod_dout;
  assign if_relu.prod_vld  = prod_vld;
  assign if_relu.bias      = bias;
  assign if_relu.out_rdy   = out_rdy;

  conv1_mac_accum #(
    .PROD_W(C_PROD_W), .N_TAPS(C_N), .ACC_W(30),
    .FRAC_SHIFT(C_FRAC), .OUT_W(C_OUT_W), .RELU_EN(0)
  ) u_dut_lin (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .sync_clr(sync_clr),
    .strm(if_lin), .busy(busy_lin)
  );

  conv1_mac_accum #(
    .PROD_W(C_PROD_W), .N_TAPS(C_N), .ACC_W(30),
    .FRAC_SHIFT(C_FRAC), .OUT_W(C_OUT_W), .RELU_EN(1)
  ) u_dut_relu (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .sync_clr(sync_clr),
    .strm(if_relu), .busy(busy_relu)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Reference: floor-divide the exact sum by 2^FRAC, ReLU, then clamp.
  function automatic longint model(input bit relu);
    longint s, q, div, hi, lo;
    s = win_bias;
    for (int i = 0; i < C_N; i++) s += win[i];
    div = longint'(1) << C_FRAC;
    if (s >= 0) q = s / div;
    else        q = -((-s + div - 1) / div);
    if (relu && q < 0) q = 0;
    hi = (longint'(1) << (C_OUT_W - 1)) - 1;
    lo = -(longint'(1) << (C_OUT_W - 1));
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q;
  endfunction

  function automatic longint rnd_prod(input int cls);
    logic signed [C_PROD_W-1:0] t;
    t = C_PROD_W'($urandom);
    if (cls == 0) return longint'(t);
    return longint'($urandom_range(0, 40000)) - 20000;
  endfunction

  task automatic fill_const(input longint b, input longint v);
    win_bias = b;
    for (int i = 0; i < C_N; i++) win[i] = v;
  endtask

  task automatic fill_rand(input int cls);
    win_bias = rnd_prod(cls);
    for (int i = 0; i < C_N; i++) win[i] = rnd_prod(cls);
  endtask

  // Present n taps of the current window; bias is only meaningful on tap 0.
  task automatic feed(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        prod_vld  = 1'b0;
        prod_dout = C_PROD_W'($urandom);
        tick();
      end
      prod_vld  = 1'b1;
      prod_dout = C_PROD_W'(win[i]);
      bias      = (i == 0) ? C_PROD_W'(win_bias) : C_PROD_W'($urandom);
      tick();
    end
    prod_vld = 1'b0;
  endtask

  task automatic expect_fin();
    check("fin_vld_lin", if_lin.out_vld, 0);
    check("fin_vld_relu", if_relu.out_vld, 0);
    check("fin_rdy", if_lin.prod_rdy, 0);
    check("fin_busy", busy_relu, 1);
    tick();
  endtask

  task automatic expect_out();
    check("out_vld_lin", if_lin.out_vld, 1);
    check("out_vld_relu", if_relu.out_vld, 1);
    check("out_data_lin", if_lin.out_data, model(0));
    check("out_data_relu", if_relu.out_data, model(1));
    check("out_rdy_low", if_relu.prod_rdy, 0);
  endtask

  task automatic handshake(input int hold);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_vld", if_lin.out_vld, 1);
      check("hold_data", if_lin.out_data, model(0));
      check("hold_rdy", if_lin.prod_rdy, 0);
    end
    out_rdy = 1'b1;
    tick();
    out_rdy  = 1'b0;
    prod_vld = 1'b0;
    check("hs_vld_lin", if_lin.out_vld, 0);
    check("hs_vld_relu", if_relu.out_vld, 0);
    check("hs_rdy_lin", if_lin.prod_rdy, 1);
    check("hs_rdy_relu", if_relu.prod_rdy, 1);
    check("hs_busy", busy_lin, 0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    ap_rst_n = 1'b1;
    check("rst_vld", if_lin.out_vld, 0);
    check("rst_data", if_relu.out_data, 0);
    check("rst_rdy", if_lin.prod_rdy, 1);
    check("rst_busy", busy_lin, 0);

    // 1: 25 x 256 back to back -> 25, FIN cycle then valid
    fill_const(0, 256);
    feed(C_N, 0);
    expect_fin();
    expect_out();
    handshake(0);

    // 2: 25 x -1000 -> -98 linear, 0 with ReLU
    fill_const(0, -1000);
    feed(C_N, 0);
    expect_fin();
    expect_out();
    check("neg_lin_const", if_lin.out_data, -98);
    handshake(1);

    // 3: positive and negative saturation without accumulator wrap
    fill_const(0, (longint'(1) << 24) - 1);
    feed(C_N, 1);
    expect_fin();
    expect_out();
    check("sat_pos_const", if_lin.out_data, 32767);
    handshake(0);
    fill_const(0, -(longint'(1) << 24));
    feed(C_N, 1);
    expect_fin();
    expect_out();
    check("sat_neg_const", if_lin.out_data, -32768);
    handshake(0);

    // 4: backpressure for 10 cycles with products pending
    fill_rand(1);
    feed(C_N, 1);
    expect_fin();
    expect_out();
    prod_vld  = 1'b1;
    prod_dout = C_PROD_W'($urandom);
    handshake(10);

    // 5: asynchronous reset mid-window
    fill_const(100, 300);
    feed(12, 0);
    check("pre_rst_busy", busy_lin, 1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("arst_busy", busy_lin, 0);
    check("arst_vld", if_relu.out_vld, 0);
    check("arst_data", if_lin.out_data, 0);
    check("arst_rdy", if_lin.prod_rdy, 1);
    tick();
    ap_rst_n = 1'b1;
    fill_const(0, 256);
    feed(C_N, 1);
    expect_fin();
    expect_out();
    handshake(0);

    // 6: sync_clr drops a coincident tap and restarts the window
    fill_const(0, 256);
    feed(7, 0);
    prod_vld  = 1'b1;
    prod_dout = C_PROD_W'(5000);
    sync_clr  = 1'b1;
    check("clr_rdy", if_lin.prod_rdy, 1);
    tick();
    sync_clr = 1'b0;
    prod_vld = 1'b0;
    check("clr_busy", busy_lin, 0);
    feed(C_N, 0);
    expect_fin();
    expect_out();
    check("clr_window_const", if_relu.out_data, 25);
    handshake(0);

    // 6b: sync_clr while the result is pending discards it
    fill_rand(1);
    feed(C_N, 0);
    expect_fin();
    expect_out();
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    check("clr_out_vld", if_lin.out_vld, 0);
    check("clr_out_rdy", if_lin.prod_rdy, 1);
    check("clr_out_busy", busy_relu, 0);

    // Randomized windows with gaps and random output stalls
    for (int w = 0; w < 10; w++) begin
      fill_rand(w % 2);
      feed(C_N, 1);
      expect_fin();
      expect_out();
      handshake($urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
